blob_centroid_tracker: RTL and testbench

- Downstream consumer of the test-pattern and camera pixel stream: pixel_data, pixel_valid, frame_start, frame_end, pixel_x, pixel_y.
- Thresholds each grey pixel into foreground or background. Accumulates the foreground pixel count, coordinate sums and bounding box over one frame.
- At frame end, computes the integer centroid with a sequential divider and publishes one result record per frame.
- Feeds the gesture classifier and arm-control logic.

---
 rtl/blob_centroid_tracker_if.sv | 43 ++++
 rtl/blob_centroid_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_blob_centroid_tracker.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blob_centroid_tracker_if.sv
// blob_centroid_tracker_if
//   Groups the pixel-stream inputs and the per-frame result record of the
//   blob centroid tracker.
//   master : pixel source / result consumer (drives the stream, reads results)
//   slave  : the tracker (reads the stream, drives busy and the result record)
//   Stream : threshold, pixel_data, pixel_valid, frame_start, frame_end,
//            pixel_x, pixel_y
//   Result : busy, result_valid, blob_found, pixel_count, centroid_x/y,
//            bbox_min_x/max_x/min_y/max_y
interface blob_centroid_tracker_if;
  logic [7:0]  threshold;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic        frame_start;
  logic        frame_end;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;

  logic        busy;
  logic        result_valid;
  logic        blob_found;
  logic [19:0] pixel_count;
  logic [15:0] centroid_x;
  logic [15:0] centroid_y;
  logic [15:0] bbox_min_x;
  logic [15:0] bbox_max_x;
  logic [15:0] bbox_min_y;
  logic [15:0] bbox_max_y;

  modport master (
    output threshold, pixel_data, pixel_valid, frame_start, frame_end,
           pixel_x, pixel_y,
    input  busy, result_valid, blob_found, pixel_count, centroid_x,
           centroid_y, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y
  );

  modport slave (
    input  threshold, pixel_data, pixel_valid, frame_start, frame_end,
           pixel_x, pixel_y,
    output busy, result_valid, blob_found, pixel_count, centroid_x,
           centroid_y, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y
  );
endinterface

// File: rtl/blob_centroid_tracker.sv
// blob_centroid_tracker
//   Thresholds a grey pixel stream, accumulates foreground count, coordinate
//   sums and bounding box over one frame, then divides the sums by the count
//   (two 32/20 restoring dividers, one quotient bit per cycle) and publishes
//   one result record per frame with a one-cycle result_valid pulse.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : blob_centroid_tracker_if.slave (pixel stream in, result record out)
module blob_centroid_tracker #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  blob_centroid_tracker_if.slave        bus
);

  localparam logic [15:0] X_LIM   = 16'(IMG_WIDTH);
  localparam logic [15:0] Y_LIM   = 16'(IMG_HEIGHT);
  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  typedef struct packed {
    logic [19:0] r;
    logic [31:0] q;
  } div_t;

  state_t      state;
  logic        closing;
  logic [7:0]  thr_q;
  logic [19:0] count;
  logic [31:0] sum_x, sum_y;
  logic [15:0] min_x, max_x, min_y, max_y;
  logic [31:0] qx, qy;
  logic [19:0] rx, ry;
  logic [4:0]  iter;

  logic        busy_q, rv_q, blob_q;
  logic [19:0] cnt_q;
  logic [15:0] cx_q, cy_q, bx0_q, bx1_q, by0_q, by1_q;

  // One restoring step: dividend bits shift out of q's MSB into the partial
  // remainder while quotient bits shift into q's LSB.
  function automatic div_t div_step(input logic [19:0] r, input logic [31:0] q,
                                    input logic [19:0] d);
    div_t        o;
    logic [20:0] t;
    t = {r, q[31]};
    if (t >= {1'b0, d}) begin
      o.r = 20'(t - {1'b0, d});
      o.q = {q[30:0], 1'b1};
    end else begin
      o.r = t[19:0];
      o.q = {q[30:0], 1'b0};
    end
    return o;
  endfunction

  logic        accepting, restart, fg;
  logic [7:0]  thr_eff;
  logic [19:0] count_n;
  logic [31:0] sum_x_n, sum_y_n;
  logic [15:0] min_x_n, max_x_n, min_y_n, max_y_n;
  div_t        sx, sy;

  // A restart clears the accumulators before the coincident pixel is folded
  // in, so that pixel lands in the new frame under the new threshold.
  always_comb begin
    accepting = (state == ACCUM) && !closing;
    restart   = accepting && bus.frame_start;
    thr_eff   = restart ? bus.threshold : thr_q;
    fg        = accepting && bus.pixel_valid && (bus.pixel_data >= thr_eff) &&
                (bus.pixel_x < X_LIM) && (bus.pixel_y < Y_LIM);
    count_n   = restart ? '0 : count;
    sum_x_n   = restart ? '0 : sum_x;
    sum_y_n   = restart ? '0 : sum_y;
    min_x_n   = restart ? '1 : min_x;
    min_y_n   = restart ? '1 : min_y;
    max_x_n   = restart ? '0 : max_x;
    max_y_n   = restart ? '0 : max_y;
    if (fg) begin
      count_n = count_n + 20'd1;
      sum_x_n = sum_x_n + {16'd0, bus.pixel_x};
      sum_y_n = sum_y_n + {16'd0, bus.pixel_y};
      if (bus.pixel_x < min_x_n) min_x_n = bus.pixel_x;
      if (bus.pixel_x > max_x_n) max_x_n = bus.pixel_x;
      if (bus.pixel_y < min_y_n) min_y_n = bus.pixel_y;
      if (bus.pixel_y > max_y_n) max_y_n = bus.pixel_y;
    end
    sx = div_step(rx, qx, count);
    sy = div_step(ry, qy, count);
  end

  // closing marks the cycle after frame_end: the count (including a pixel
  // coincident with frame_end) is settled there before choosing DIVIDE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      closing <= 1'b0;
      thr_q   <= '0;
      count   <= '0;
      sum_x   <= '0;
      sum_y   <= '0;
      min_x   <= '0;
      max_x   <= '0;
      min_y   <= '0;
      max_y   <= '0;
      qx      <= '0;
      qy      <= '0;
      rx      <= '0;
      ry      <= '0;
      iter    <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      blob_q  <= 1'b0;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      bx0_q   <= '0;
      bx1_q   <= '0;
      by0_q   <= '0;
      by1_q   <= '0;
    end else begin
      rv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            thr_q   <= bus.threshold;
            count   <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
            min_x   <= '1;
            min_y   <= '1;
            max_x   <= '0;
            max_y   <= '0;
            closing <= 1'b0;
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (!closing) begin
            thr_q <= thr_eff;
            count <= count_n;
            sum_x <= sum_x_n;
            sum_y <= sum_y_n;
            min_x <= min_x_n;
            max_x <= max_x_n;
            min_y <= min_y_n;
            max_y <= max_y_n;
            if (bus.frame_end) closing <= 1'b1;
          end else begin
            closing <= 1'b0;
            busy_q  <= 1'b1;
            if (count >= MIN_CNT) begin
              qx    <= sum_x;
              qy    <= sum_y;
              rx    <= '0;
              ry    <= '0;
              iter  <= '0;
              state <= DIVIDE;
            end else begin
              state <= DONE;
            end
          end
        end
        DIVIDE: begin
          qx   <= sx.q;
          rx   <= sx.r;
          qy   <= sy.q;
          ry   <= sy.r;
          iter <= iter + 5'd1;
          if (iter == 5'd31) state <= DONE;
        end
        DONE: begin
          rv_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= count;
          state  <= IDLE;
          if (count >= MIN_CNT) begin
            blob_q <= 1'b1;
            cx_q   <= qx[15:0];
            cy_q   <= qy[15:0];
            bx0_q  <= min_x;
            bx1_q  <= max_x;
            by0_q  <= min_y;
            by1_q  <= max_y;
          end else begin
            blob_q <= 1'b0;
            cx_q   <= '0;
            cy_q   <= '0;
            bx0_q  <= '0;
            bx1_q  <= '0;
            by0_q  <= '0;
            by1_q  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
  assign bus.blob_found   = blob_q;
  assign bus.pixel_count  = cnt_q;
  assign bus.centroid_x   = cx_q;
  assign bus.centroid_y   = cy_q;
  assign bus.bbox_min_x   = bx0_q;
  assign bus.bbox_max_x   = bx1_q;
  assign bus.bbox_min_y   = by0_q;
  assign bus.bbox_max_y   = by1_q;

endmodule

// File: tb/tb_blob_centroid_tracker.sv
// tb_blob_centroid_tracker
//   Drives reduced-size (64x48) frames through blob_centroid_tracker and
//   checks every published record against a scoreboard of expected results.
module tb_blob_centroid_tracker;

  localparam int W = 64;
  localparam int H = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blob_centroid_tracker_if bus ();

  blob_centroid_tracker #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .MIN_PIXELS(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // pat: 0 vertical bars, 1 horizontal bars, 2 all zero, 3 rectangle
  typedef struct {
    int         pat;
    logic [7:0] thr;
    int         rx0, ry0, rw, rh;
    bit         sof;
    int         cnt;
    bit         blob;
    int         cx, cy, bx0, bx1, by0, by1;
    int         lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   edge_no;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] grey(input vec_t v, input int x, input int y);
    int b;
    case (v.pat)
      0: b = x / (W / 4);
      1: b = y / (H / 4);
      2: return 8'd0;
      default:
        return (x >= v.rx0 && x < v.rx0 + v.rw && y >= v.ry0 && y < v.ry0 + v.rh)
               ? 8'hFF : 8'h00;
    endcase
    case (b)
      0:       return 8'd0;
      1:       return 8'd85;
      2:       return 8'd170;
      default: return 8'd255;
    endcase
  endfunction

  // Raster frame; frame_end rides on the last pixel. After row 0 an invalid
  // bright pixel and three out-of-range bright pixels are inserted.
  task automatic drive_frame(input vec_t v, input bit push, output int fe_edge);
    exp_t e;
    bus.threshold = v.thr;
    if (!v.sof) begin
      bus.frame_start = 1'b1;
      bus.pixel_valid = 1'b0;
      step();
      bus.frame_start = 1'b0;
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (x == 0 && y == 1) begin
          bus.frame_start = 1'b0;
          bus.pixel_valid = 1'b0;
          bus.pixel_data  = 8'hFF;
          bus.pixel_x     = 16'd0;
          bus.pixel_y     = 16'd0;
          step();
          bus.pixel_valid = 1'b1;
          bus.pixel_x     = 16'(W);
          bus.pixel_y     = 16'd0;
          step();
          bus.pixel_x     = 16'd0;
          bus.pixel_y     = 16'(H);
          step();
          bus.pixel_x     = '1;
          bus.pixel_y     = '1;
          step();
        end
        bus.pixel_valid = 1'b1;
        bus.pixel_x     = 16'(x);
        bus.pixel_y     = 16'(y);
        bus.pixel_data  = grey(v, x, y);
        bus.frame_start = v.sof && x == 0 && y == 0;
        bus.frame_end   = (x == W - 1) && (y == H - 1);
        step();
      end
    end
    fe_edge         = cyc;
    bus.pixel_valid = 1'b0;
    bus.frame_end   = 1'b0;
    bus.frame_start = 1'b0;
    if (push) begin
      e.v       = v;
      e.edge_no = fe_edge + v.lat;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) step();
    chk("result_timeout_pending", sbq.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_result_valid"}, bus.result_valid, 0);
    chk({tag, "_blob_found"}, bus.blob_found, 0);
    chk({tag, "_pixel_count"}, bus.pixel_count, 0);
    chk({tag, "_centroid_x"}, bus.centroid_x, 0);
    chk({tag, "_centroid_y"}, bus.centroid_y, 0);
    chk({tag, "_bbox_min_x"}, bus.bbox_min_x, 0);
    chk({tag, "_bbox_max_x"}, bus.bbox_max_x, 0);
    chk({tag, "_bbox_min_y"}, bus.bbox_min_y, 0);
    chk({tag, "_bbox_max_y"}, bus.bbox_max_y, 0);
  endtask

  // Result monitor: every result_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: result_valid=1 at cycle %0d, expected 0 (no frame pending)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("latency_edge", cyc, mon_e.edge_no);
        chk("pixel_count", bus.pixel_count, mon_e.v.cnt);
        chk("blob_found", bus.blob_found, mon_e.v.blob);
        chk("centroid_x", bus.centroid_x, mon_e.v.cx);
        chk("centroid_y", bus.centroid_y, mon_e.v.cy);
        chk("bbox_min_x", bus.bbox_min_x, mon_e.v.bx0);
        chk("bbox_max_x", bus.bbox_max_x, mon_e.v.bx1);
        chk("bbox_min_y", bus.bbox_min_y, mon_e.v.by0);
        chk("bbox_max_y", bus.bbox_max_y, mon_e.v.by1);
        chk("busy_with_result", bus.busy, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    vec_t rs;
    int   fe, fe2;

    //        pat thr  rx0 ry0 rw rh sof cnt   blob cx  cy  bx0 bx1 by0 by1 lat
    vt[0] = '{0, 200, 0,  0,  0, 0, 0,  768,  1,   55, 23, 48, 63, 0,  47, 34};
    vt[1] = '{1, 200, 0,  0,  0, 0, 0,  768,  1,   31, 41, 0,  63, 36, 47, 34};
    vt[2] = '{0, 0,   0,  0,  0, 0, 0,  3072, 1,   31, 23, 0,  63, 0,  47, 34};
    vt[3] = '{2, 1,   0,  0,  0, 0, 0,  0,    0,   0,  0,  0,  0,  0,  0,  2};
    vt[4] = '{3, 128, 30, 20, 8, 8, 0,  64,   1,   33, 23, 30, 37, 20, 27, 34};
    vt[5] = '{3, 128, 30, 20, 7, 9, 0,  63,   0,   0,  0,  0,  0,  0,  0,  2};
    vt[6] = '{1, 170, 0,  0,  0, 0, 0,  1536, 1,   31, 35, 0,  63, 24, 47, 34};

    bus.threshold   = '0;
    bus.pixel_data  = '0;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.pixel_x     = '0;
    bus.pixel_y     = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_zero("reset");

    for (int i = 0; i < 7; i++) begin
      drive_frame(vt[i], 1'b1, fe);
      wait_drain();
      repeat (5) step();
    end

    // Frame arriving 10 cycles into DIVIDE is dropped; busy spans DIVIDE+DONE.
    drive_frame(vt[0], 1'b1, fe);
    chk("busy_at_close", bus.busy, 0);
    fork
      begin
        for (int k = 1; k <= 34; k++) begin
          step();
          chk("busy_window", bus.busy, (k <= 33) ? 1 : 0);
        end
      end
      begin
        repeat (10) step();
        drive_frame(vt[2], 1'b0, fe2);
      end
    join
    wait_drain();
    repeat (60) step();

    // Reset mid-divide discards the frame and clears every output.
    drive_frame(vt[0], 1'b0, fe);
    repeat (16) step();
    chk("busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("mid_divide_rst");
    repeat (60) step();
    drive_frame(vt[0], 1'b1, fe);
    wait_drain();
    repeat (5) step();

    // Restart inside ACCUM: junk is discarded, new threshold latched, and the
    // pixel coincident with the restart pulse belongs to the new frame.
    bus.threshold   = 8'd0;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_x     = 16'd1;
      bus.pixel_y     = 16'd1;
      bus.pixel_data  = 8'hFF;
      step();
    end
    bus.pixel_valid = 1'b0;
    rs     = vt[4];
    rs.sof = 1'b1;
    drive_frame(rs, 1'b1, fe);
    wait_drain();
    repeat (5) step();

    chk("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
